// File: rtl/ntsc_fb_writer.sv
// Pixel capture FIFO and SRAM write scheduler for the NTSC-to-VGA path.
// Optional line doubling is enabled by defining FBW_LINE_DOUBLE_EN.
module ntsc_fb_writer #(
    parameter int DEPTH_LOG2 = 9,
    parameter int X_W        = 9,
    parameter int Y_W        = 9,
    parameter int COLOR_W    = 8,
    parameter int DATA_W     = 16,
    parameter int DROP_W     = 16
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic                  iPix_valid,
    input  logic [COLOR_W-1:0]    iPix_color,
    input  logic [X_W-1:0]        iPix_x,
    input  logic [Y_W-1:0]        iPix_y,
    input  logic                  iGrant,
    output logic [X_W+Y_W-1:0]    oSram_addr,
    output logic [DATA_W-1:0]     oSram_data,
    output logic                  oSram_we_n,
    output logic                  oEmpty,
    output logic                  oFull,
    output logic [DEPTH_LOG2:0]   oLevel,
    output logic [DROP_W-1:0]     oDrop_cnt
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int ENTRY_W = COLOR_W + X_W + Y_W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WR   = 2'd1;
`ifdef FBW_LINE_DOUBLE_EN
    localparam logic [1:0] WR2  = 2'd2;
`endif

    logic [ENTRY_W-1:0]    mem [DEPTH];
    logic [ENTRY_W-1:0]    head_reg;
    logic                  pending_reg;
    logic [DEPTH_LOG2:0]   wr_ptr_reg;
    logic [DEPTH_LOG2:0]   rd_ptr_reg;
    logic [DROP_W-1:0]     drop_cnt_reg;
    logic [1:0]            state_reg;
    logic [1:0]            state_next;
    logic [X_W+Y_W-1:0]    addr_reg;
    logic [DATA_W-1:0]     data_reg;
    logic                  we_n_reg;

    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  drop;
    logic                  pop;
    logic                  issue;
    logic                  consume;
    logic [Y_W-1:0]        row;
    logic [X_W-1:0]        head_x;
    logic [COLOR_W-1:0]    head_color;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[DEPTH_LOG2] != rd_ptr_reg[DEPTH_LOG2]) &&
                   (wr_ptr_reg[DEPTH_LOG2-1:0] == rd_ptr_reg[DEPTH_LOG2-1:0]);
    assign push  = iPix_valid & ~full;
    assign drop  = iPix_valid & full;

    // head_reg is a one-entry stage between the RAM read and the SRAM port;
    // a write goes out only on a granted edge.
    assign issue = pending_reg & iGrant;
    assign pop   = iGrant & ~empty & (~pending_reg | consume);

    assign head_x     = head_reg[X_W+Y_W-1:Y_W];
    assign head_color = head_reg[ENTRY_W-1 -: COLOR_W];

`ifdef FBW_LINE_DOUBLE_EN
    logic odd_row;

    always_comb begin
        state_next = state_reg;
        consume    = 1'b0;
        odd_row    = 1'b0;
        if (issue) begin
            if (state_reg == WR2) begin
                odd_row    = 1'b1;
                consume    = 1'b1;
                state_next = WR;
            end else begin
                state_next = WR2;
            end
        end else if (state_reg != WR2) begin
            state_next = IDLE;
        end
    end

    assign row = {head_reg[Y_W-2:0], odd_row};
`else
    always_comb begin
        consume    = issue;
        state_next = issue ? WR : IDLE;
    end

    assign row = head_reg[Y_W-1:0];
`endif

    // Storage kept free of reset so it maps onto block RAM with a registered read.
    always_ff @(posedge iCLK) begin
        if (push) begin
            mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= {iPix_color, iPix_x, iPix_y};
        end
        if (pop) begin
            head_reg <= mem[rd_ptr_reg[DEPTH_LOG2-1:0]];
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            drop_cnt_reg <= '0;
            pending_reg  <= 1'b0;
            state_reg    <= IDLE;
            addr_reg     <= '0;
            data_reg     <= '0;
            we_n_reg     <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (drop && (drop_cnt_reg != {DROP_W{1'b1}})) begin
                drop_cnt_reg <= drop_cnt_reg + 1'b1;
            end
            pending_reg <= pop | (pending_reg & ~consume);
            state_reg   <= state_next;
            we_n_reg    <= ~issue;
            if (issue) begin
                addr_reg <= {head_x, row};
                data_reg <= {{(DATA_W-COLOR_W){1'b0}}, head_color};
            end
        end
    end

    assign oSram_addr = addr_reg;
    assign oSram_data = data_reg;
    assign oSram_we_n = we_n_reg;
    assign oEmpty     = empty;
    assign oFull      = full;
    assign oLevel     = wr_ptr_reg - rd_ptr_reg;
    assign oDrop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_ntsc_fb_writer.sv
// Self-checking bench for ntsc_fb_writer: random pixel traffic against a queue of
// expected SRAM writes; follows FBW_LINE_DOUBLE_EN when it is defined.
module tb_ntsc_fb_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [7:0]  color;
    logic [8:0]  px;
    logic [8:0]  py;
    logic        grant;
    logic [17:0] addr;
    logic [15:0] data;
    logic        we_n;
    logic        empty;
    logic        full;
    logic [9:0]  level;
    logic [15:0] drop_cnt;

    logic        s_valid;
    logic [7:0]  s_color;
    logic [8:0]  s_x;
    logic [8:0]  s_y;
    logic        s_grant;
    logic [17:0] s_addr;
    logic [15:0] s_data;
    logic        s_we_n;
    logic        s_empty;
    logic        s_full;
    logic [2:0]  s_level;
    logic [1:0]  s_drop;

    logic [33:0] exp_q[$];
    logic [33:0] obs_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ntsc_fb_writer dut (
        .iCLK(clk), .iRST_N(rst_n), .iPix_valid(valid), .iPix_color(color),
        .iPix_x(px), .iPix_y(py), .iGrant(grant), .oSram_addr(addr),
        .oSram_data(data), .oSram_we_n(we_n), .oEmpty(empty), .oFull(full),
        .oLevel(level), .oDrop_cnt(drop_cnt)
    );

    ntsc_fb_writer #(.DEPTH_LOG2(2), .DROP_W(2)) u_small (
        .iCLK(clk), .iRST_N(rst_n), .iPix_valid(s_valid), .iPix_color(s_color),
        .iPix_x(s_x), .iPix_y(s_y), .iGrant(s_grant), .oSram_addr(s_addr),
        .oSram_data(s_data), .oSram_we_n(s_we_n), .oEmpty(s_empty), .oFull(s_full),
        .oLevel(s_level), .oDrop_cnt(s_drop)
    );

    always @(negedge clk) begin
        if (rst_n === 1'b1 && we_n === 1'b0) obs_q.push_back({addr, data});
    end

    // Reference: each accepted pixel becomes one or two {addr, data} writes, in order.
    function automatic void add_exp(input logic [7:0] c, input logic [8:0] x, input logic [8:0] y);
`ifdef FBW_LINE_DOUBLE_EN
        exp_q.push_back({x, y[7:0], 1'b0, 8'h00, c});
        exp_q.push_back({x, y[7:0], 1'b1, 8'h00, c});
`else
        exp_q.push_back({x, y, 8'h00, c});
`endif
    endfunction

    task automatic push_rand(input bit record);
        logic [7:0] c;
        logic [8:0] x;
        logic [8:0] y;
        c = 8'($urandom);
        x = 9'($urandom);
        y = 9'($urandom);
        valid = 1'b1;
        color = c;
        px    = x;
        py    = y;
        if (record) add_exp(c, x, y);
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (empty && we_n && obs_q.size() >= exp_q.size()) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        bit ok;
        @(negedge clk);
        rst_n = 1'b1;
        grant = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push_rand(1'b0);
            @(negedge clk);
        end
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_rand(1'b0);
            @(negedge clk);
        end
        n_checks += 7;
        if (addr !== 18'd0)     begin n_fail++; $display("FAIL reset_addr got %h want 0", addr); end
        if (data !== 16'd0)     begin n_fail++; $display("FAIL reset_data got %h want 0", data); end
        if (we_n !== 1'b1)      begin n_fail++; $display("FAIL reset_we_n got %b want 1", we_n); end
        if (empty !== 1'b1)     begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
        if (full !== 1'b0)      begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
        if (level !== 10'd0)    begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
        if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
        rst_n = 1'b1;
        valid = 1'b0;
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            push_rand(1'b1);
            @(negedge clk);
        end
        valid = 1'b0;
        wait_drain(200, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL reset_drain timeout got %0d writes want %0d", obs_q.size(), exp_q.size()); end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL reset_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            $display("reset write %0d addr=%h data=%h", i, obs_q[i][33:16], obs_q[i][15:0]);
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL reset_stream[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete();
        exp_q.delete();
        grant = 1'b0;
    endtask

    task automatic test_latency;
        @(negedge clk);
        obs_q.delete();
        grant = 1'b1;
        valid = 1'b1;
        color = 8'h3A;
        px    = 9'd5;
        py    = 9'd7;
        @(negedge clk);
        valid = 1'b0;
        n_checks++;
        if (we_n !== 1'b1) begin n_fail++; $display("FAIL latency_n1 we_n got %b want 1", we_n); end
        @(negedge clk);
        n_checks++;
        if (we_n !== 1'b1) begin n_fail++; $display("FAIL latency_n2 we_n got %b want 1", we_n); end
        @(negedge clk);
        n_checks += 3;
        $display("latency write addr=%h data=%h we_n=%b", addr, data, we_n);
        if (we_n !== 1'b0) begin n_fail++; $display("FAIL latency_we_n got %b want 0", we_n); end
`ifdef FBW_LINE_DOUBLE_EN
        if (addr !== {9'd5, 9'd14}) begin n_fail++; $display("FAIL latency_addr got %h want %h", addr, {9'd5, 9'd14}); end
`else
        if (addr !== {9'd5, 9'd7}) begin n_fail++; $display("FAIL latency_addr got %h want %h", addr, {9'd5, 9'd7}); end
`endif
        if (data !== 16'h003A) begin n_fail++; $display("FAIL latency_data got %h want 003a", data); end
        @(negedge clk);
`ifdef FBW_LINE_DOUBLE_EN
        n_checks += 2;
        if (we_n !== 1'b0) begin n_fail++; $display("FAIL latency_odd_we_n got %b want 0", we_n); end
        if (addr !== {9'd5, 9'd15}) begin n_fail++; $display("FAIL latency_odd_addr got %h want %h", addr, {9'd5, 9'd15}); end
        @(negedge clk);
`endif
        n_checks++;
        if (we_n !== 1'b1) begin n_fail++; $display("FAIL latency_after we_n got %b want 1", we_n); end
        grant = 1'b0;
        repeat (2) @(negedge clk);
        obs_q.delete();
    endtask

    task automatic test_overflow;
        bit ok;
        grant = 1'b0;
        for (int i = 0; i < 515; i++) begin
            push_rand(i < 512);
            s_valid = (i < 9);
            s_color = 8'($urandom);
            s_x     = 9'($urandom);
            s_y     = 9'($urandom);
            @(negedge clk);
        end
        valid   = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        n_checks += 7;
        $display("overflow level=%0d full=%b drop=%0d small_drop=%0d", level, full, drop_cnt, s_drop);
        if (full !== 1'b1)       begin n_fail++; $display("FAIL ovf_full got %b want 1", full); end
        if (empty !== 1'b0)      begin n_fail++; $display("FAIL ovf_empty got %b want 0", empty); end
        if (level !== 10'd512)   begin n_fail++; $display("FAIL ovf_level got %0d want 512", level); end
        if (drop_cnt !== 16'd3)  begin n_fail++; $display("FAIL ovf_drop got %0d want 3", drop_cnt); end
        if (s_drop !== 2'd3)     begin n_fail++; $display("FAIL sat_drop got %0d want 3", s_drop); end
        if (s_level !== 3'd4)    begin n_fail++; $display("FAIL sat_level got %0d want 4", s_level); end
        if (s_full !== 1'b1)     begin n_fail++; $display("FAIL sat_full got %b want 1", s_full); end
        grant = 1'b1;
        wait_drain(3000, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL ovf_drain timeout got %0d writes want %0d", obs_q.size(), exp_q.size()); end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ovf_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            $display("overflow write %0d addr=%h data=%h", i, obs_q[i][33:16], obs_q[i][15:0]);
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_stream[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks += 2;
        if (full !== 1'b0)      begin n_fail++; $display("FAIL ovf_after_full got %b want 0", full); end
        if (drop_cnt !== 16'd3) begin n_fail++; $display("FAIL ovf_after_drop got %0d want 3", drop_cnt); end
        obs_q.delete();
        exp_q.delete();
        grant = 1'b0;
    endtask

    task automatic test_traffic;
        bit ok;
        grant = 1'b1;
        for (int i = 0; i < 600; i++) begin
`ifndef FBW_LINE_DOUBLE_EN
            n_checks++;
            if (level > 10'd1) begin n_fail++; $display("FAIL traffic_level cycle %0d got %0d want <=1", i, level); end
`endif
            push_rand(1'b1);
            @(negedge clk);
        end
        valid = 1'b0;
        wait_drain(3000, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL traffic_drain timeout got %0d writes want %0d", obs_q.size(), exp_q.size()); end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL traffic_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            $display("traffic write %0d addr=%h data=%h", i, obs_q[i][33:16], obs_q[i][15:0]);
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL traffic_stream[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete();
        exp_q.delete();
        grant = 1'b0;
    endtask

    task automatic test_grant_loss;
        bit ok;
        bit g_prev;
        logic [9:0] lvl_prev;
        grant = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push_rand(1'b1);
            @(negedge clk);
        end
        valid    = 1'b0;
        g_prev   = 1'b1;
        lvl_prev = level;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i > 0 && !g_prev) begin
                n_checks += 2;
                if (we_n !== 1'b1) begin n_fail++; $display("FAIL gloss_we_n cycle %0d got %b want 1", i, we_n); end
                if (level !== lvl_prev) begin n_fail++; $display("FAIL gloss_level cycle %0d got %0d want %0d", i, level, lvl_prev); end
            end
            g_prev   = (i < 3) ? 1'b1 : (i == 3) ? 1'b0 : 1'($urandom_range(0, 1));
            grant    = g_prev;
            lvl_prev = level;
        end
        grant = 1'b1;
        wait_drain(200, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL gloss_drain timeout got %0d writes want %0d", obs_q.size(), exp_q.size()); end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL gloss_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            $display("grant_loss write %0d addr=%h data=%h", i, obs_q[i][33:16], obs_q[i][15:0]);
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL gloss_stream[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete();
        exp_q.delete();
        grant = 1'b0;
    endtask

`ifdef FBW_LINE_DOUBLE_EN
    task automatic test_line_double;
        bit ok;
        logic [5:0] pattern;
        pattern = 6'b101001;
        @(negedge clk);
        valid = 1'b1;
        color = 8'h11;
        px    = 9'd2;
        py    = 9'd3;
        add_exp(8'h11, 9'd2, 9'd3);
        @(negedge clk);
        valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            grant = pattern[i];
            @(negedge clk);
        end
        grant = 1'b1;
        wait_drain(50, ok);
        n_checks += 2;
        if (!ok) begin n_fail++; $display("FAIL dbl_drain timeout got %0d writes want 2", obs_q.size()); end
        if (obs_q.size() != 2) begin n_fail++; $display("FAIL dbl_count got %0d want 2", obs_q.size()); end
        if (obs_q.size() >= 2) begin
            n_checks += 2;
            $display("line_double rows %0d %0d", obs_q[0][24:16], obs_q[1][24:16]);
            if (obs_q[0][24:16] !== 9'd6) begin n_fail++; $display("FAIL dbl_row_even got %0d want 6", obs_q[0][24:16]); end
            if (obs_q[1][24:16] !== 9'd7) begin n_fail++; $display("FAIL dbl_row_odd got %0d want 7", obs_q[1][24:16]); end
        end
        obs_q.delete();
        exp_q.delete();
        grant = 1'b0;
    endtask
`endif

    initial begin
        rst_n   = 1'b0;
        valid   = 1'b0;
        color   = '0;
        px      = '0;
        py      = '0;
        grant   = 1'b0;
        s_valid = 1'b0;
        s_color = '0;
        s_x     = '0;
        s_y     = '0;
        s_grant = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_latency();
        test_overflow();
        test_traffic();
        test_grant_loss();
`ifdef FBW_LINE_DOUBLE_EN
        test_line_double();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
